branch_predictor: RTL and testbench

//  Fetch-side 2-bit-counter branch predictor (PHT). Combinational taken/not-taken guess for the fetch PC.

---
 rtl/branch_predictor_pkg.sv | 17 +
 rtl/branch_predictor_sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 126 ++++++++++++
 tb/tb_branch_predictor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-side 2-bit-counter branch predictor.
// Counter encodings and FSM states used by branch_predictor and sat_counter2.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BPU_SNT = 2'b00,
        BPU_WNT = 2'b01,
        BPU_WT  = 2'b10,
        BPU_ST  = 2'b11
    } cnt_e;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: combinational 2-bit saturating counter step.
// Counts up on taken, down on not-taken, holding at the strong ends.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != BPU_ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != BPU_SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side PHT branch predictor with EX-stage training and mispredict flag.
// Optional gshare indexing when BPU_GSHARE_EN is defined.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int GHR_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             upd_pred_taken,
    output logic             mispredict,
    output logic             ready
);

    localparam int DEPTH = 1 << IDX_W;

    state_e           state;
    state_e           state_next;
    logic [IDX_W-1:0] init_cnt;
    logic [1:0]       pht [DEPTH];

    logic             wr_valid;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_cnt;

    logic             upd_accept;
    logic [1:0]       upd_cur;
    logic [1:0]       upd_next;
    logic [1:0]       pred_cnt;

    logic             pht_we;
    logic [IDX_W-1:0] pht_waddr;
    logic [1:0]       pht_wdata;

    logic             unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_INIT;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            S_INIT: if (init_cnt == '1) state_next = S_RUN;
            S_RUN:  ready = 1'b1;
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn)              init_cnt <= '0;
        else if (state == S_INIT) init_cnt <= init_cnt + IDX_W'(1);
    end

    assign upd_accept = upd_valid & (state == S_RUN);

`ifdef BPU_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    always_ff @(posedge clk) begin
        if (!resetn || state == S_INIT) ghr <= '0;
        else if (upd_accept)            ghr <= GHR_W'({ghr, upd_taken});
    end

    assign pred_idx = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr);
`else
    assign pred_idx = pred_pc[IDX_W+1:2];
`endif

    // A write still in flight in the second stage is newer than the array contents.
    assign upd_cur  = (wr_valid && wr_idx == upd_idx)  ? wr_cnt : pht[upd_idx];
    assign pred_cnt = (wr_valid && wr_idx == pred_idx) ? wr_cnt : pht[pred_idx];
    assign pred_taken = ready & pred_cnt[1];

    sat_counter2 u_sat (
        .cnt      (upd_cur),
        .taken    (upd_taken),
        .cnt_next (upd_next)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_valid   <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            wr_valid   <= upd_accept;
            mispredict <= upd_accept & (upd_taken != upd_pred_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (upd_accept) begin
            wr_idx <= upd_idx;
            wr_cnt <= upd_next;
        end
    end

    // Single write port shared by initialisation and training keeps the PHT LUTRAM-friendly.
    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = wr_idx;
        pht_wdata = wr_cnt;
        if (state == S_INIT) begin
            pht_we    = 1'b1;
            pht_waddr = init_cnt;
            pht_wdata = BPU_WNT;
        end else if (wr_valid) begin
            pht_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pht_we) pht[pht_waddr] <= pht_wdata;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against a table-of-counters reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [5:0]  pred_idx;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic        mispredict;
    logic        ready;

    int nvec = 0;
    int nerr = 0;

    // Reference model state
    int unsigned cnt_m [64];
    bit          ready_m;
    int unsigned init_m;
    logic [5:0]  ghr_m;
    bit          mis_m;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(6), .GHR_W(6)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_idx       (pred_idx),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_taken      (upd_taken),
        .upd_pred_taken (upd_pred_taken),
        .mispredict     (mispredict),
        .ready          (ready)
    );

    function automatic logic [5:0] m_idx(input logic [31:0] pc);
`ifdef BPU_GSHARE_EN
        return pc[7:2] ^ ghr_m;
`else
        return pc[7:2];
`endif
    endfunction

    function automatic logic m_taken(input logic [31:0] pc);
        return ready_m && (cnt_m[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] pc_for(input logic [5:0] idx);
        logic [31:0] pc;
`ifdef BPU_GSHARE_EN
        pc = {24'h0, idx ^ ghr_m, 2'b00};
`else
        pc = {24'h0, idx, 2'b00};
`endif
        return pc;
    endfunction

    // Apply one clock edge to the model using the inputs currently driven, then to the DUT.
    task automatic tick();
        mis_m = resetn && ready_m && upd_valid && (upd_taken != upd_pred_taken);
        if (!resetn) begin
            ready_m = 1'b0;
            init_m  = 0;
            ghr_m   = '0;
        end else if (!ready_m) begin
            cnt_m[init_m] = 1;
            init_m++;
            if (init_m == 64) ready_m = 1'b1;
        end else if (upd_valid) begin
            if (upd_taken) cnt_m[upd_idx] = (cnt_m[upd_idx] == 3) ? 3 : cnt_m[upd_idx] + 1;
            else           cnt_m[upd_idx] = (cnt_m[upd_idx] == 0) ? 0 : cnt_m[upd_idx] - 1;
            ghr_m = {ghr_m[4:0], upd_taken};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic update(input logic [5:0] idx, input logic tk, input logic ptk);
        upd_valid = 1'b1; upd_idx = idx; upd_taken = tk; upd_pred_taken = ptk;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_pred_taken = 1'b0;
        pred_pc = 32'h0;
        tick(); tick();
        nvec++;
        if (ready !== 1'b0 || mispredict !== 1'b0) begin
            nerr++; $display("FAIL reset_state: ready=%b mispredict=%b, want 0 0", ready, mispredict);
        end
        resetn = 1'b1;
        // Updates offered during initialisation must be ignored.
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pred_taken = 1'b0;
        for (int unsigned i = 0; i < 64; i++) begin
            pred_pc = $urandom; upd_idx = 6'($urandom);
            #1;
            nvec++;
            if (ready !== 1'b0 || pred_taken !== 1'b0 || mispredict !== 1'b0) begin
                nerr++;
                $display("FAIL init_cycle %0d: ready=%b pred_taken=%b mispredict=%b, want 0 0 0",
                         i, ready, pred_taken, mispredict);
            end
            tick();
        end
        upd_valid = 1'b0;
        nvec++;
        if (ready !== 1'b1) begin
            nerr++; $display("FAIL ready_after_init: got %b want 1", ready);
        end
    endtask

    task automatic test_train();
        for (int unsigned k = 0; k < 2; k++) begin
            update(6'd5, 1'b1, 1'b0);
            pred_pc = pc_for(6'd5); #1;
            nvec++;
            if (pred_taken !== m_taken(pred_pc) || pred_idx !== m_idx(pred_pc)) begin
                nerr++; $display("FAIL train step %0d: pred_taken=%b idx=%0d, want %b %0d",
                                 k, pred_taken, pred_idx, m_taken(pred_pc), m_idx(pred_pc));
            end
            tick(); tick();
        end
    endtask

    task automatic test_saturate();
        for (int unsigned k = 0; k < 4; k++) begin
            update(6'd5, 1'b0, 1'b1);
            pred_pc = pc_for(6'd5); #1;
            nvec++;
            if (pred_taken !== m_taken(pred_pc)) begin
                nerr++; $display("FAIL saturate step %0d: pred_taken=%b want %b",
                                 k, pred_taken, m_taken(pred_pc));
            end
        end
        nvec++;
        if (cnt_m[5] != 0 || pred_taken !== 1'b0) begin
            nerr++; $display("FAIL saturate_floor: pred_taken=%b model=%0d want 0 0", pred_taken, cnt_m[5]);
        end
    endtask

    task automatic test_back_to_back();
        logic tk [3] = '{1'b1, 1'b1, 1'b0};
        for (int unsigned k = 0; k < 3; k++) begin
            update(6'd9, tk[k], 1'b1);
            pred_pc = pc_for(6'd9); #1;
            nvec++;
            if (pred_taken !== m_taken(pred_pc)) begin
                nerr++; $display("FAIL back_to_back step %0d: pred_taken=%b want %b",
                                 k, pred_taken, m_taken(pred_pc));
            end
        end
        tick();
        pred_pc = pc_for(6'd9); #1;
        nvec++;
        if (pred_taken !== 1'b1 || cnt_m[9] != 2) begin
            nerr++; $display("FAIL back_to_back_final: pred_taken=%b model=%0d want 1 2", pred_taken, cnt_m[9]);
        end
    endtask

    task automatic test_mispredict();
        update(6'd20, 1'b1, 1'b0);
        nvec++;
        if (mispredict !== 1'b1 || mis_m !== 1'b1) begin
            nerr++; $display("FAIL mispredict_pulse: got %b want 1", mispredict);
        end
        tick();
        nvec++;
        if (mispredict !== 1'b0) begin
            nerr++; $display("FAIL mispredict_clear: got %b want 0", mispredict);
        end
        update(6'd20, 1'b1, 1'b1);
        nvec++;
        if (mispredict !== 1'b0) begin
            nerr++; $display("FAIL mispredict_match: got %b want 0", mispredict);
        end
        update(6'd20, 1'b0, 1'b1);
        nvec++;
        if (mispredict !== 1'b1) begin
            nerr++; $display("FAIL mispredict_nt: got %b want 1", mispredict);
        end
    endtask

    task automatic test_midop_reset();
        update(6'd3, 1'b1, 1'b1);
        update(6'd3, 1'b1, 1'b1);
        pred_pc = pc_for(6'd3); #1;
        nvec++;
        if (pred_taken !== 1'b1 || cnt_m[3] != 3) begin
            nerr++; $display("FAIL midop_trained: pred_taken=%b model=%0d want 1 3", pred_taken, cnt_m[3]);
        end
        upd_valid = 1'b1; upd_idx = 6'd3; upd_taken = 1'b1; upd_pred_taken = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        upd_valid = 1'b0;
        nvec++;
        if (ready !== 1'b0 || mispredict !== 1'b0) begin
            nerr++; $display("FAIL midop_reset_state: ready=%b mispredict=%b want 0 0", ready, mispredict);
        end
        for (int unsigned i = 0; i < 64; i++) tick();
        pred_pc = pc_for(6'd3); #1;
        nvec++;
        if (ready !== 1'b1 || pred_taken !== 1'b0 || pred_idx !== m_idx(pred_pc)) begin
            nerr++; $display("FAIL midop_after_init: ready=%b pred_taken=%b idx=%0d want 1 0 %0d",
                             ready, pred_taken, pred_idx, m_idx(pred_pc));
        end
    endtask

    task automatic test_random();
        for (int unsigned n = 0; n < 400; n++) begin
            upd_valid      = ($urandom_range(0, 3) != 0);
            upd_idx        = 6'($urandom_range(0, 7));
            upd_taken      = 1'($urandom);
            upd_pred_taken = 1'($urandom);
            pred_pc        = ($urandom_range(0, 1) != 0) ? {24'h0, 3'b000, 3'($urandom), 2'b00} : $urandom;
            tick();
            nvec++;
            if (pred_taken !== m_taken(pred_pc) || pred_idx !== m_idx(pred_pc) ||
                mispredict !== mis_m || ready !== ready_m) begin
                nerr++;
                $display("FAIL random %0d: taken=%b idx=%0d mis=%b rdy=%b want %b %0d %b %b",
                         n, pred_taken, pred_idx, mispredict, ready,
                         m_taken(pred_pc), m_idx(pred_pc), mis_m, ready_m);
            end
        end
        upd_valid = 1'b0;
    endtask

    initial begin
        ready_m = 1'b0; init_m = 0; ghr_m = '0; mis_m = 1'b0;
        for (int unsigned i = 0; i < 64; i++) cnt_m[i] = 1;
        test_reset();
        test_train();
        test_saturate();
        test_back_to_back();
        test_mispredict();
        test_midop_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
